// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_pkg;

  localparam int          PC_STEP   = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misaligned;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - control, instruction-memory and decode handshake bundle of the fetch unit
interface fetch_unit_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            fetch_en;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            if_valid;
  logic            if_ready;
  logic [ILEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            if_misaligned;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    output imem_req_valid, imem_addr, if_valid, if_instr, if_pc, if_misaligned
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc, if_misaligned
  );
endinterface

// File: rtl/fetch_unit_sync_fifo.sv
// rtl/fetch_unit_sync_fifo.sv - single-clock FIFO with flush; pop-then-push allowed when full
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !reset && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, pipelined imem requester and prefetch queue with redirect flush
// FETCH_MISALIGN_TRAP_EN: misaligned redirect enqueues one marker entry and parks in FAULT
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int KW = CW + 4;
  localparam int EW = XLEN + ILEN + 1;

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [XLEN-1:0] r_fetch_pc;
  logic [KW-1:0]   r_kill;

  logic            w_redirect;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_credit_ok;
  logic            w_rsp_push;
  logic            w_mark_push;
  logic [XLEN-1:0] w_mark_pc;
  logic            w_q_push;
  logic            w_q_pop;
  logic [EW-1:0]   w_q_din;
  logic [EW-1:0]   w_q_head;
  logic [CW-1:0]   w_q_count;
  logic [XLEN-1:0] w_tag_pc;
  logic [CW-1:0]   w_tag_count;
  logic [KW-1:0]   w_kill_base;
  logic [KW-1:0]   w_kill_redirect;
  logic            w_if_valid;

  assign w_redirect  = bus.redirect_valid;
  // The tag FIFO holds exactly the live (non-killed) requests, so its count is the outstanding count.
  assign w_credit_ok = ((CW+1)'(w_q_count) + (CW+1)'(w_tag_count)) < (CW+1)'(DEPTH);
  assign w_req_fire  = w_req_valid && bus.imem_req_ready;

  always_comb begin
    w_state_next = r_state;
    w_req_valid  = 1'b0;
    if (!reset && r_state == FETCH && bus.fetch_en && !w_redirect && w_credit_ok)
      w_req_valid = 1'b1;
    if (w_redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      w_state_next = (bus.redirect_pc[1:0] != 2'b00) ? FAULT : FETCH;
`else
      w_state_next = FETCH;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_state_next;
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic            r_mark_pend;
  logic [XLEN-1:0] r_mark_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mark_pend <= 1'b0;
      r_mark_pc   <= '0;
    end else begin
      r_mark_pend <= w_redirect && (bus.redirect_pc[1:0] != 2'b00);
      if (w_redirect) r_mark_pc <= bus.redirect_pc;
    end
  end

  assign w_mark_push = r_mark_pend && !w_redirect;
  assign w_mark_pc   = r_mark_pc;
`else
  assign w_mark_push = 1'b0;
  assign w_mark_pc   = '0;
`endif

  assign w_rsp_push = bus.imem_rsp_valid && !w_redirect && (r_kill == '0) && !w_mark_push;
  assign w_q_push   = w_rsp_push || w_mark_push;
  assign w_q_din    = w_mark_push ? {1'b1, ILEN'(NOP_INSTR), w_mark_pc}
                                  : {1'b0, bus.imem_rsp_data, w_tag_pc};
  assign w_if_valid = (w_q_count != '0);
  assign w_q_pop    = w_if_valid && bus.if_ready && !w_redirect;

  // A response arriving in the redirect cycle is dropped, so it is taken off the kill total here.
  assign w_kill_base     = r_kill + KW'(w_tag_count);
  assign w_kill_redirect = (bus.imem_rsp_valid && (w_kill_base != '0)) ? w_kill_base - KW'(1)
                                                                        : w_kill_base;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_kill     <= '0;
    end else if (w_redirect) begin
      r_fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      r_kill     <= w_kill_redirect;
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
      if (bus.imem_rsp_valid && (r_kill != '0)) r_kill <= r_kill - KW'(1);
    end
  end

  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_req_fire),
    .i_data (r_fetch_pc),
    .i_pop  (w_rsp_push),
    .i_flush(w_redirect),
    .o_data (w_tag_pc),
    .o_count(w_tag_count)
  );

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_prefetch_q (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_q_push),
    .i_data (w_q_din),
    .i_pop  (w_q_pop),
    .i_flush(w_redirect),
    .o_data (w_q_head),
    .o_count(w_q_count)
  );

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_addr      = r_fetch_pc;
  assign bus.if_valid       = w_if_valid;
  assign bus.if_pc          = w_if_valid ? w_q_head[XLEN-1:0] : '0;
  assign bus.if_instr       = w_if_valid ? w_q_head[XLEN+ILEN-1:XLEN] : '0;
  assign bus.if_misaligned  = w_if_valid && w_q_head[EW-1];
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit (FETCH_MISALIGN_TRAP_EN aware)
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32), .ILEN(32)) bus ();

  fetch_unit #(.XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    logic        if_ready;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc, lat, n_pops, n_fires, first_valid;
  logic drv_reset, drv_fetch_en, drv_redirect, drv_if_ready, drv_req_ready;
  logic [31:0] drv_redirect_pc;
  logic s_req_valid, s_if_valid, s_if_mis;
  logic [31:0] s_addr, s_if_pc, s_if_instr;
  rsp_t         mem_q[$];
  fetch_entry_t exp_q[$];
  vec_t         tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    fetch_entry_t e;
    @(negedge clk);
    if (!drv_reset && mem_q.size() > 0 && mem_q[0].due == cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_q[0].data;
      void'(mem_q.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
    reset              = drv_reset;
    bus.fetch_en       = drv_fetch_en;
    bus.redirect_valid = drv_redirect;
    bus.redirect_pc    = drv_redirect_pc;
    bus.if_ready       = drv_if_ready;
    bus.imem_req_ready = drv_req_ready;
    #1;
    s_req_valid = bus.imem_req_valid;
    s_addr      = bus.imem_addr;
    s_if_valid  = bus.if_valid;
    s_if_pc     = bus.if_pc;
    s_if_instr  = bus.if_instr;
    s_if_mis    = bus.if_misaligned;
    if (!drv_reset) begin
      if (s_if_valid && drv_if_ready && !drv_redirect) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got pc %h expected no entry (cycle %0d)", s_if_pc, cyc);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", s_if_pc, e.pc);
          check("pop_instr", s_if_instr, e.instr);
          check("pop_mis", 32'(s_if_mis), 32'(e.misaligned));
        end
      end
      if (drv_redirect) begin
        exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
        if (drv_redirect_pc[1:0] != 2'b00)
          exp_q.push_back('{pc: drv_redirect_pc, instr: NOP_INSTR, misaligned: 1'b1});
`endif
      end
      if (s_req_valid && drv_req_ready) begin
        n_fires++;
        mem_q.push_back('{due: cyc + lat, data: s_addr});
        exp_q.push_back('{pc: s_addr, instr: s_addr, misaligned: 1'b0});
      end
      if (s_if_valid && first_valid < 0) first_valid = cyc;
      cyc++;
    end
  endtask

  task automatic do_reset(input int l);
    drv_reset       = 1'b1;
    drv_fetch_en    = 1'b0;
    drv_redirect    = 1'b0;
    drv_redirect_pc = '0;
    drv_if_ready    = 1'b0;
    drv_req_ready   = 1'b1;
    step();
    step();
    drv_reset   = 1'b0;
    mem_q.delete();
    exp_q.delete();
    cyc         = 0;
    lat         = l;
    n_pops      = 0;
    n_fires     = 0;
    first_valid = -1;
  endtask

  task automatic run_pops(input int n, input int max_cyc, input string name);
    for (int i = 0; i < max_cyc && n_pops < n; i++) step();
    check(name, 32'(n_pops), 32'(n));
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    drv_redirect    = 1'b1;
    drv_redirect_pc = pc;
    step();
    drv_redirect    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1);
  end

  initial begin
    int f0;
    tbl[0] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h0};
    for (int i = 4; i < 10; i++) tbl[i] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0};

    // reset state
    do_reset(1);
    step();
    check("rst_req_valid", 32'(s_req_valid), 32'd0);
    check("rst_addr", s_addr, 32'h0);
    check("rst_if_valid", 32'(s_if_valid), 32'd0);
    check("rst_if_pc", s_if_pc, 32'h0);
    check("rst_if_instr", s_if_instr, 32'h0);
    check("rst_if_mis", 32'(s_if_mis), 32'd0);

    // streaming with 1-cycle memory
    do_reset(1);
    drv_fetch_en = 1'b1;
    drv_if_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check("stream_req_valid", 32'(s_req_valid), 32'd1);
      check("stream_addr", s_addr, 32'(4 * c));
      check("stream_if_valid", 32'(s_if_valid), 32'(c >= 2));
      if (c >= 2) check("stream_if_pc", s_if_pc, 32'(4 * (c - 2)));
    end
    check("stream_first_valid", 32'(first_valid), 32'd2);

    // decode backpressure: table-driven
    do_reset(1);
    drv_fetch_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drv_if_ready = tbl[i].if_ready;
      step();
      check("bp_req_valid", 32'(s_req_valid), 32'(tbl[i].exp_rv));
      check("bp_addr", s_addr, tbl[i].exp_addr);
      check("bp_if_valid", 32'(s_if_valid), 32'(tbl[i].exp_iv));
      if (tbl[i].exp_iv) check("bp_if_pc", s_if_pc, tbl[i].exp_pc);
    end
    check("bp_fires", 32'(n_fires), 32'd4);
    drv_if_ready = 1'b1;
    run_pops(5, 20, "bp_resume_pops");

    // 3-cycle memory, redirect with three requests in flight
    do_reset(3);
    drv_fetch_en = 1'b1;
    drv_if_ready = 1'b1;
    step(); step(); step();
    redirect_to(32'h100);
    step();
    check("lat3_req_valid", 32'(s_req_valid), 32'd1);
    check("lat3_addr", s_addr, 32'h100);
    run_pops(2, 20, "lat3_pops");
    check("lat3_first_valid", 32'(first_valid), 32'd8);

    // redirect coinciding with pop and response
    do_reset(1);
    drv_fetch_en = 1'b1;
    drv_if_ready = 1'b1;
    step(); step(); step();
    redirect_to(32'h200);
    check("rdpop_req_in_redirect", 32'(s_req_valid), 32'd0);
    check("rdpop_head_present", 32'(s_if_valid), 32'd1);
    step();
    check("rdpop_q_empty", 32'(s_if_valid), 32'd0);
    check("rdpop_req_valid", 32'(s_req_valid), 32'd1);
    check("rdpop_addr", s_addr, 32'h200);
    run_pops(n_pops + 2, 10, "rdpop_pops");

    // imem_req_ready stall, with fetch_en withdrawn for one stalled cycle
    do_reset(1);
    drv_fetch_en = 1'b1;
    drv_if_ready = 1'b1;
    step(); step();
    drv_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drv_fetch_en = (i != 2);
      step();
      check("stall_req_valid", 32'(s_req_valid), 32'(i != 2));
      check("stall_addr", s_addr, 32'h8);
    end
    drv_fetch_en  = 1'b1;
    drv_req_ready = 1'b1;
    step();
    check("stall_accept_valid", 32'(s_req_valid), 32'd1);
    check("stall_accept_addr", s_addr, 32'h8);
    step();
    check("stall_next_addr", s_addr, 32'hC);
    run_pops(4, 15, "stall_pops");

    // back-to-back redirects under 3-cycle latency
    do_reset(3);
    drv_fetch_en = 1'b1;
    drv_if_ready = 1'b1;
    step(); step(); step();
    drv_redirect    = 1'b1;
    drv_redirect_pc = 32'h400;
    step();
    drv_redirect_pc = 32'h500;
    step();
    drv_redirect = 1'b0;
    run_pops(3, 30, "b2b_pops");
    check("b2b_first_valid", 32'(first_valid), 32'd9);

    // PC wrap-around
    do_reset(1);
    drv_fetch_en = 1'b1;
    drv_if_ready = 1'b1;
    redirect_to(32'hFFFF_FFF8);
    step(); step(); step();
    check("wrap_req_valid", 32'(s_req_valid), 32'd1);
    check("wrap_addr", s_addr, 32'h0);
    run_pops(3, 10, "wrap_pops");

    // misaligned redirect target
    do_reset(1);
    drv_fetch_en = 1'b1;
    drv_if_ready = 1'b1;
    step(); step(); step();
    redirect_to(32'h102);
    step();
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_no_req", 32'(s_req_valid), 32'd0);
    step();
    check("mis_if_valid", 32'(s_if_valid), 32'd1);
    check("mis_flag", 32'(s_if_mis), 32'd1);
    check("mis_pc", s_if_pc, 32'h102);
    check("mis_instr", s_if_instr, 32'h13);
    f0 = n_fires;
    for (int i = 0; i < 8; i++) step();
    check("mis_fault_fires", 32'(n_fires - f0), 32'd0);
    check("mis_fault_if_valid", 32'(s_if_valid), 32'd0);
    redirect_to(32'h300);
    step();
    check("mis_resume_valid", 32'(s_req_valid), 32'd1);
    check("mis_resume_addr", s_addr, 32'h300);
    run_pops(n_pops + 2, 10, "mis_resume_pops");
`else
    f0 = n_pops;
    check("mis_req_valid", 32'(s_req_valid), 32'd1);
    check("mis_addr", s_addr, 32'h100);
    run_pops(f0 + 2, 10, "mis_pops");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end. It replaces the single-cycle PC register and next-PC mux path of the RV32I core.
- Owns the PC and issues pipelined, in-order requests to instruction memory.
- Buffers returned instructions in a DEPTH-entry prefetch queue and hands them to decode through a valid/ready handshake.
- Supports redirect (branch/jump/trap) with flush of queued entries and of in-flight responses.

Parameters:
XLEN, 32, width of PC and address bus
ILEN, 32, instruction width
DEPTH, 4, prefetch queue entries, power of two, >= 2
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  in  1  core clock, rising edge
reset  in  1  synchronous active-high reset
fetch_en  in  1  permits new memory requests when 1
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  XLEN  restart target
imem_req_valid  out  1  memory request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  XLEN  request address
imem_rsp_valid  in  1  response valid, strictly in order, latency >= 1
imem_rsp_data  in  ILEN  response instruction
if_valid  out  1  queue head valid
if_ready  in  1  decode consumes head
if_instr  out  ILEN  head instruction
if_pc  out  XLEN  head PC
if_misaligned  out  1  head is misaligned-target marker (0 unless macro defined)

Behaviour:
- Single clock domain. Reset is synchronous and active-high on clk/reset, and has priority over every other event.
- Reset values: fetch_pc=RESET_PC; queue empty; outstanding=0; kill=0; state=FETCH; all outputs 0.
- State machine: FETCH (normal); FAULT (exists only with the macro).
- Issue rule: imem_req_valid=1 iff state==FETCH && fetch_en && !redirect_valid && (count+outstanding) < DEPTH. This credit rule guarantees the queue never overflows.
- imem_addr=fetch_pc. On req_valid&&req_ready: fetch_pc += 4, outstanding += 1.
- A stalled request (valid && !ready) holds its address stable. Dropping fetch_en while stalled is allowed; the request is withdrawn.
- Response handling, when kill>0: response dropped, kill decrements.
- Response handling, otherwise: push {pc_tag, data}, outstanding decrements. pc_tag comes from a small in-flight PC FIFO, or equivalently response PC = head_pc + 4*(count).
- Push and pop in the same cycle are legal at any fill level, including full when popping.
- Output: if_valid=!empty; if_instr/if_pc are the registered head. if_valid && if_ready pops. Head fields are stable while if_valid && !if_ready.
- Redirect (one cycle, highest priority after reset):
  - queue cleared and any same-cycle pop ignored;
  - fetch_pc = redirect_pc with [1:0] forced to 0;
  - kill = outstanding + kill − (response this cycle ? 1 : 0), and outstanding = 0;
  - no request issued in the redirect cycle; first request to the new PC in the next cycle.
- Redirect with simultaneous response: the response is dropped.
- Back-to-back redirects: the last one wins; kill accumulates correctly.
- Wrap-around: fetch_pc wraps modulo 2^XLEN silently.
- Throughput: one instruction per cycle steady state with 1-cycle memory. Latency request → if_valid = memory latency + 1.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined, redirect with redirect_pc[1:0]!=0:
  - flush as normal;
  - in the next cycle, enqueue one marker entry: if_misaligned=1, if_pc=redirect_pc (unmodified), if_instr=32'h0000_0013 (NOP);
  - state → FAULT, no requests issued;
  - leave FAULT only on the next redirect or reset.
- Undefined: low bits forced to 0, FAULT state absent, if_misaligned tied 0.

Decomposition:
- Package fetch_pkg holds:
  - typedef fetch_entry_t {pc, instr, misaligned};
  - NOP constant 32'h0000_0013;
  - state enum {FETCH, FAULT};
  - PC_STEP=4.
- One sub-module: sync_fifo (parametrised width/depth, push/pop/flush, count). Used for the prefetch queue and the in-flight PC tags.

Test Plan:
- Reset, fetch_en=1, 1-cycle memory returning addr as data, if_ready=1 → if_pc sequence 0,4,8,12, one per cycle after first valid at cycle 2; if_instr==if_pc.
- if_ready=0 for 10 cycles → exactly DEPTH=4 requests issued (0..C), req_valid then 0; if_pc=0 held stable; resume yields 0,4,8,C,10 with no loss or duplication.
- 3-cycle memory latency, 3 requests in flight, redirect_pc=0x100 → the 3 old responses dropped; next if_pc=0x100, then 0x104.
- Redirect in the same cycle as if_valid&&if_ready and a response → neither popped nor pushed; queue empty next cycle; first request addr=0x200 the cycle after redirect.
- imem_req_ready=0 for 5 cycles → imem_addr stable at 0x8; accepted once ready=1; PC advances to 0xC.
- With FETCH_MISALIGN_TRAP_EN, redirect_pc=0x102 → one entry if_misaligned=1, if_pc=0x102, if_instr=0x13; no further requests until redirect_pc=0x300 resumes at 0x300. Without the macro, same stimulus fetches from 0x100.
